pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter register and next-PC sequencer for the single-cycle CPU. It consumes the PC+4 value and the branch/jump decision from decode, and updates the PC on the clock edge. It freezes the PC while memory asserts BUSYWAIT and latches any branch or jump decision taken during a stall. It drives the instruction-memory address and feeds the dedicated PC adder.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset
- IMM_WIDTH, 8, width of the signed branch/jump word offset
- CLK  input  1  system clock, all state updates on posedge
- RESET  input  1  synchronous, active-high reset
- BUSYWAIT  input  1  OR of instruction- and data-memory busywait; high = stall
- BEQ_signal  input  1  decode: current instruction is beq
- J_signal  input  1  decode: current instruction is j
- ZERO  input  1  ALU zero flag for the current instruction
- IMMEDIATE  input  IMM_WIDTH  signed word offset from the instruction
- PC  output  32  current PC, instruction-memory address
- PC_PLUS4  output  32  PC + 4, combinational from PC
- FETCH_EN  output  1  instruction-memory read enable
- REDIRECT_PENDING  output  1  a captured branch/jump is waiting for the stall to end

## Operation
- States: RUN and STALL. Reset enters RUN.
- Offset: off = sign_extend(IMMEDIATE) << 2, computed in 32 bits.
- Target: tgt = PC_PLUS4 + off, modulo 2^32. Wrap-around is silent; there is no trap.
- Decision in RUN, with priority J > BEQ:
  - J_signal gives tgt.
  - BEQ_signal & ZERO gives tgt.
  - Otherwise PC_PLUS4.
- RUN, BUSYWAIT low at the edge: PC ← decision. Stay in RUN.
- RUN, BUSYWAIT high at the edge:
  - PC holds.
  - The decision is stored in the pend_pc register.
  - pend_valid ← 1 only if the decision differs from the sequential path (taken branch or jump).
  - Go to STALL.
- STALL: BEQ_signal, J_signal, ZERO and IMMEDIATE are ignored. The held instruction's decision is already captured.
- STALL, BUSYWAIT high: hold PC, pend_pc and pend_valid.
- STALL, BUSYWAIT low at the edge:
  - PC ← pend_pc.
  - pend_valid ← 0.
  - Go to RUN.
- J and BEQ both high: J wins. BEQ without ZERO is not taken.
- FETCH_EN = !RESET. It stays high during a stall so that memory keeps the request.
- REDIRECT_PENDING = pend_valid.

## Timing
- Reset: at a posedge with RESET high:
  - PC ← RESET_PC, state ← RUN.
  - pend_pc ← RESET_PC, pend_valid ← 0.
  - FETCH_EN low while RESET is high. PC_PLUS4 = RESET_PC + 4.
- RESET overrides everything on the same edge, including a stall in progress. Any pending redirect is dropped.
- Sequential step latency: 1 cycle. A taken branch or jump lands in 1 cycle when not stalled.
- Stall of N cycles (BUSYWAIT high on N consecutive edges): the PC changes on the first edge with BUSYWAIT low.
- BUSYWAIT is sampled only at posedge. Glitches between edges have no effect.
- PC_PLUS4, tgt and REDIRECT_PENDING are combinational from registers and inputs. No output changes except at posedge or on an input change.

## Configuration
- Macro: PC_SEQUENCER_BNE_EN.
- Defined:
  - Adds the input port BNE_signal (1 bit).
  - The decision gains BNE_signal & !ZERO gives tgt.
  - Priority becomes J > BEQ > BNE.
  - BEQ and BNE both high selects tgt if either condition holds.
- Undefined: the port does not exist and only beq and j redirect.

## Structure
- Shared CPU package holds:
  - the state encoding typedef (RUN=1'b0, STALL=1'b1);
  - the PC width constant (32);
  - the instruction step constant (4);
  - the RESET_PC default.
- Sub-module next_pc_sel: combinational decision and target computation, covering sign extension, shift, add and priority mux. The top level holds the state register, PC and pend_pc/pend_valid.

## Test plan
- Reset: RESET high for 2 cycles, then low with BUSYWAIT=0 → PC=0, FETCH_EN=0 during reset. Then PC=4, 8, 12 on successive edges.
- Taken beq: PC=0x10, BEQ=1, ZERO=1, IMMEDIATE=8'hFE, no stall → next PC = 0x14 − 8 = 0x0C. With ZERO=0 → 0x14.
- Jump during stall: PC=0x20, J=1, IMMEDIATE=8'd3, BUSYWAIT high for 3 edges.
  - PC stays 0x20 and REDIRECT_PENDING=1.
  - Decode inputs are toggled during the stall and are ignored.
  - On the first edge with BUSYWAIT low → PC=0x30 and REDIRECT_PENDING=0.
- Wrap-around: PC=0xFFFFFFFC, no branch → PC=0x00000000. PC=0xFFFFFFF8, J=1, IMMEDIATE=8'd2 → PC=0x00000004.
- Reset mid-stall: pending jump captured, RESET asserted while BUSYWAIT is high → PC=RESET_PC, REDIRECT_PENDING=0, state RUN.
- Priority (PC_SEQUENCER_BNE_EN defined): J=1, BEQ=1, BNE=1, ZERO=0, IMMEDIATE=8'd1 at PC=0 → PC=0x08. J=0, BEQ=0, BNE=1, ZERO=1 → PC=0x04.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared CPU constants and the PC sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    localparam int          PC_W             = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Branch/jump target computation and next-PC priority select.
//               Optional bne support when PC_SEQUENCER_BNE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import pc_sequencer_pkg::*;
#(
    parameter int IMM_WIDTH = 8
) (
    input  logic [PC_W-1:0]      pc_plus4_i,
    input  logic                 beq_i,
    input  logic                 j_i,
    input  logic                 zero_i,
`ifdef PC_SEQUENCER_BNE_EN
    input  logic                 bne_i,
`endif
    input  logic [IMM_WIDTH-1:0] imm_i,
    output logic [PC_W-1:0]      next_pc_o,
    output logic                 taken_o
);

    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_tgt;
    logic            w_taken;

    // Word offset becomes a byte offset; the add wraps modulo 2^32.
    assign w_off = {{(PC_W-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i} << 2;
    assign w_tgt = pc_plus4_i + w_off;

    always_comb begin
        w_taken = 1'b0;
        if (j_i) begin
            w_taken = 1'b1;
        end else if (beq_i && zero_i) begin
            w_taken = 1'b1;
        end
`ifdef PC_SEQUENCER_BNE_EN
        else if (bne_i && !zero_i) begin
            w_taken = 1'b1;
        end
`endif
    end

    assign taken_o   = w_taken;
    assign next_pc_o = w_taken ? w_tgt : pc_plus4_i;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : PC register with stall handling and captured redirects.
//               Macro PC_SEQUENCER_BNE_EN adds the BNE_signal input.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          IMM_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 BUSYWAIT,
    input  logic                 BEQ_signal,
    input  logic                 J_signal,
`ifdef PC_SEQUENCER_BNE_EN
    input  logic                 BNE_signal,
`endif
    input  logic                 ZERO,
    input  logic [IMM_WIDTH-1:0] IMMEDIATE,
    output logic [PC_W-1:0]      PC,
    output logic [PC_W-1:0]      PC_PLUS4,
    output logic                 FETCH_EN,
    output logic                 REDIRECT_PENDING
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            pend_valid_q, pend_valid_d;

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_decision;
    logic            w_taken;

    assign w_pc_plus4 = pc_q + PC_STEP;

    next_pc_sel #(
        .IMM_WIDTH (IMM_WIDTH)
    ) u_next_pc_sel (
        .pc_plus4_i (w_pc_plus4),
        .beq_i      (BEQ_signal),
        .j_i        (J_signal),
        .zero_i     (ZERO),
`ifdef PC_SEQUENCER_BNE_EN
        .bne_i      (BNE_signal),
`endif
        .imm_i      (IMMEDIATE),
        .next_pc_o  (w_decision),
        .taken_o    (w_taken)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        unique case (state_q)
            ST_RUN: begin
                if (BUSYWAIT) begin
                    // Decode only holds this instruction's decision now, so capture it.
                    pend_pc_d    = w_decision;
                    pend_valid_d = w_taken;
                    state_d      = ST_STALL;
                end else begin
                    pc_d = w_decision;
                end
            end
            ST_STALL: begin
                if (!BUSYWAIT) begin
                    pc_d         = pend_pc_q;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign PC               = pc_q;
    assign PC_PLUS4         = w_pc_plus4;
    assign FETCH_EN         = !RESET;
    assign REDIRECT_PENDING = pend_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed vector table and corner sequences for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic        BEQ_signal;
    logic        J_signal;
    logic        BNE_signal;
    logic        ZERO;
    logic [7:0]  IMMEDIATE;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FETCH_EN;
    logic        REDIRECT_PENDING;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .RESET_PC  (32'd0),
        .IMM_WIDTH (8)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .BUSYWAIT         (BUSYWAIT),
        .BEQ_signal       (BEQ_signal),
        .J_signal         (J_signal),
`ifdef PC_SEQUENCER_BNE_EN
        .BNE_signal       (BNE_signal),
`endif
        .ZERO             (ZERO),
        .IMMEDIATE        (IMMEDIATE),
        .PC               (PC),
        .PC_PLUS4         (PC_PLUS4),
        .FETCH_EN         (FETCH_EN),
        .REDIRECT_PENDING (REDIRECT_PENDING)
    );

    typedef struct {
        logic        rst;
        logic        busy;
        logic        beq;
        logic        j;
        logic        bne;
        logic        zero;
        logic [7:0]  imm;
        logic [31:0] exp_pc;
        logic        exp_pend;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic busy, input logic beq,
                       input logic j, input logic bne, input logic zero,
                       input logic [7:0] imm, input logic [31:0] exp_pc,
                       input logic exp_pend);
        vec_t v;
        v.rst = rst; v.busy = busy; v.beq = beq; v.j = j; v.bne = bne;
        v.zero = zero; v.imm = imm; v.exp_pc = exp_pc; v.exp_pend = exp_pend;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        RESET      = v.rst;
        BUSYWAIT   = v.busy;
        BEQ_signal = v.beq;
        J_signal   = v.j;
        BNE_signal = v.bne;
        ZERO       = v.zero;
        IMMEDIATE  = v.imm;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " PC"}, PC, v.exp_pc);
        check({tag, " PC_PLUS4"}, PC_PLUS4, v.exp_pc + 32'd4);
        check({tag, " PEND"}, {31'd0, REDIRECT_PENDING}, {31'd0, v.exp_pend});
        check({tag, " FETCH_EN"}, {31'd0, FETCH_EN}, {31'd0, !v.rst});
    endtask

    task automatic run_table(input string tag);
        foreach (tv[i]) begin
            @(negedge CLK);
            drive(tv[i]);
            @(posedge CLK);
            #1;
            check_all($sformatf("%s[%0d]", tag, i), tv[i]);
        end
        tv.delete();
    endtask

    initial begin
        vec_t v;
        RESET = 1'b1; BUSYWAIT = 1'b0; BEQ_signal = 1'b0; J_signal = 1'b0;
        BNE_signal = 1'b0; ZERO = 1'b0; IMMEDIATE = 8'd0;

        //   rst busy beq j bne zero imm    exp_pc        pend
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0004, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0008, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_000C, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0010, 0);
        add(0, 0, 1, 0, 0, 1, 8'hFE, 32'h0000_000C, 0); // taken beq backwards
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0010, 0);
        add(0, 0, 1, 0, 0, 0, 8'hFE, 32'h0000_0014, 0); // beq not taken
        add(0, 0, 0, 1, 0, 0, 8'h02, 32'h0000_0020, 0);
        add(0, 1, 0, 1, 0, 0, 8'h03, 32'h0000_0020, 1); // jump captured in stall
        add(0, 1, 1, 0, 0, 1, 8'h80, 32'h0000_0020, 1);
        add(0, 1, 0, 1, 0, 0, 8'hFF, 32'h0000_0020, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0030, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0034, 0);
        add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0000_0034, 0); // sequential stall
        add(0, 0, 0, 1, 0, 0, 8'h05, 32'h0000_0038, 0); // release ignores decode
        add(0, 0, 0, 1, 0, 0, 8'hF0, 32'hFFFF_FFFC, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0); // sequential wrap
        add(0, 0, 0, 1, 0, 0, 8'hFD, 32'hFFFF_FFF8, 0);
        add(0, 0, 0, 1, 0, 0, 8'h02, 32'h0000_0004, 0); // target wrap
        add(0, 1, 0, 1, 0, 0, 8'h03, 32'h0000_0004, 1);
        add(1, 1, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0); // reset mid-stall
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0004, 0);
        add(0, 0, 1, 1, 0, 0, 8'h01, 32'h0000_000C, 0); // j wins over untaken beq
        run_table("tbl");

        // BUSYWAIT pulse between edges must not stall
        @(negedge CLK);
        v.rst = 0; v.busy = 0; v.beq = 0; v.j = 0; v.bne = 0; v.zero = 0;
        v.imm = 8'h00; v.exp_pc = 32'h0000_0010; v.exp_pend = 0;
        drive(v);
        BUSYWAIT = 1'b1;
        #2 BUSYWAIT = 1'b0;
        @(posedge CLK);
        #1;
        check_all("glitch", v);

        // Stall with the captured jump released after a long hold
        @(negedge CLK);
        J_signal = 1'b1; IMMEDIATE = 8'h04; BUSYWAIT = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        J_signal = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            check("long stall PC", PC, 32'h0000_0010);
            check("long stall PEND", {31'd0, REDIRECT_PENDING}, 32'd1);
        end
        @(negedge CLK);
        BUSYWAIT = 1'b0;
        @(posedge CLK);
        #1;
        check("long stall release PC", PC, 32'h0000_0024);
        check("long stall release PEND", {31'd0, REDIRECT_PENDING}, 32'd0);

`ifdef PC_SEQUENCER_BNE_EN
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0);
        add(0, 0, 1, 1, 1, 0, 8'h01, 32'h0000_0008, 0); // j highest priority
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0);
        add(0, 0, 0, 0, 1, 1, 8'h01, 32'h0000_0004, 0); // bne with zero not taken
        add(0, 0, 0, 0, 1, 0, 8'h02, 32'h0000_0010, 0); // bne taken
        add(0, 0, 1, 0, 1, 0, 8'h01, 32'h0000_0018, 0); // beq fails, bne holds
        add(0, 0, 1, 0, 1, 1, 8'hFF, 32'h0000_0018, 0); // beq holds
        run_table("bne");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
